// File: rtl/regfile_sb_if.sv
// Register file access bundle: decode-side reads/locks, writeback-side write, PC slot source.
interface regfile_sb_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 4
);
    logic [ADDR_W-1:0] A1;
    logic [ADDR_W-1:0] A2;
    logic [DATA_W-1:0] RD1;
    logic [DATA_W-1:0] RD2;
    logic              BUSY1;
    logic              BUSY2;
    logic [ADDR_W-1:0] A3;
    logic [DATA_W-1:0] WD3;
    logic              WE3;
    logic [DATA_W-1:0] R15;
    logic              LOCK_EN;
    logic [ADDR_W-1:0] LOCK_A;

    modport master (
        output A1, A2, A3, WD3, WE3, R15, LOCK_EN, LOCK_A,
        input  RD1, RD2, BUSY1, BUSY2
    );

    modport slave (
        input  A1, A2, A3, WD3, WE3, R15, LOCK_EN, LOCK_A,
        output RD1, RD2, BUSY1, BUSY2
    );
endinterface

// File: rtl/regfile_sb.sv
// Two-read/one-write register file with PC slot and per-register pending-write scoreboard.
// Optional same-edge write-to-read forwarding under macro REGFILE_BYPASS_EN.
module regfile_sb #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned PC_IDX = 15
) (
    input logic         CLK,
    input logic         RST_N,
    regfile_sb_if.slave bus
);
    localparam int unsigned     NREG = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_IDX);

    logic [DATA_W-1:0] mem [NREG];
    logic [NREG-1:0]   pend;
    logic [NREG-1:0]   pend_nxt;
    logic              wr_ok;
    logic              lk_ok;
    logic [ADDR_W-1:0] ra [2];
    logic [DATA_W-1:0] rd_c [2];
    logic [1:0]        busy_c;

    assign wr_ok = bus.WE3 && (bus.A3 != PC_A);
    assign lk_ok = bus.LOCK_EN && (bus.LOCK_A != PC_A);
    assign ra[0] = bus.A1;
    assign ra[1] = bus.A2;

    // Lock is applied after the clear so a same-address collision stays pending.
    always_comb begin
        pend_nxt = pend;
        if (wr_ok) pend_nxt[bus.A3] = 1'b0;
        if (lk_ok) pend_nxt[bus.LOCK_A] = 1'b1;
    end

    // Per-port read value selection; PC slot overrides everything.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_c[p]   = mem[ra[p]];
            busy_c[p] = pend[ra[p]];
`ifdef REGFILE_BYPASS_EN
            if (wr_ok && (bus.A3 == ra[p])) begin
                rd_c[p]   = bus.WD3;
                busy_c[p] = lk_ok && (bus.LOCK_A == ra[p]);
            end
`endif
            if (ra[p] == PC_A) begin
                rd_c[p]   = bus.R15;
                busy_c[p] = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < int'(NREG); i++) mem[i] <= '0;
        end else if (wr_ok) begin
            mem[bus.A3] <= bus.WD3;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pend      <= '0;
            bus.RD1   <= '0;
            bus.RD2   <= '0;
            bus.BUSY1 <= 1'b0;
            bus.BUSY2 <= 1'b0;
        end else begin
            pend      <= pend_nxt;
            bus.RD1   <= rd_c[0];
            bus.RD2   <= rd_c[1];
            bus.BUSY1 <= busy_c[0];
            bus.BUSY2 <= busy_c[1];
        end
    end
endmodule

// File: tb/tb_regfile_sb.sv
// Directed table-driven bench for regfile_sb, with hand-written reset sequences.
module tb_regfile_sb;
    logic CLK;
    logic RST_N;

    regfile_sb_if #(.DATA_W(32), .ADDR_W(4)) bus ();

    regfile_sb #(.DATA_W(32), .ADDR_W(4), .PC_IDX(15)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic [3:0]  a1;
        logic [3:0]  a2;
        logic        we3;
        logic [3:0]  a3;
        logic [31:0] wd3;
        logic [31:0] r15;
        logic        lock_en;
        logic [3:0]  lock_a;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic        e_b1;
        logic        e_b2;
    } vec_t;

    localparam int NV = 20;
    vec_t vt [NV];
    int   n_vec;
    int   n_mis;

    function automatic vec_t mk(input logic [3:0] a1, input logic [3:0] a2, input logic we3,
                                input logic [3:0] a3, input logic [31:0] wd3, input logic [31:0] r15,
                                input logic lock_en, input logic [3:0] lock_a,
                                input logic [31:0] e_rd1, input logic [31:0] e_rd2,
                                input logic e_b1, input logic e_b2);
        vec_t v;
        v.a1 = a1; v.a2 = a2; v.we3 = we3; v.a3 = a3; v.wd3 = wd3; v.r15 = r15;
        v.lock_en = lock_en; v.lock_a = lock_a;
        v.e_rd1 = e_rd1; v.e_rd2 = e_rd2; v.e_b1 = e_b1; v.e_b2 = e_b2;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.A1 = '0; bus.A2 = '0; bus.A3 = '0; bus.WD3 = '0; bus.WE3 = 1'b0;
        bus.R15 = '0; bus.LOCK_EN = 1'b0; bus.LOCK_A = '0;
    endtask

    task automatic apply(input vec_t v);
        @(negedge CLK);
        bus.A1 = v.a1; bus.A2 = v.a2; bus.WE3 = v.we3; bus.A3 = v.a3; bus.WD3 = v.wd3;
        bus.R15 = v.r15; bus.LOCK_EN = v.lock_en; bus.LOCK_A = v.lock_a;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_outs(input string nm, input logic [31:0] r1, input logic [31:0] r2,
                            input logic b1, input logic b2);
        chk({nm, " rd1"}, bus.RD1, r1);
        chk({nm, " rd2"}, bus.RD2, r2);
        chk({nm, " busy1"}, 32'(bus.BUSY1), 32'(b1));
        chk({nm, " busy2"}, 32'(bus.BUSY2), 32'(b2));
    endtask

    initial begin
        n_vec = 0;
        n_mis = 0;
        //     a1 a2 we a3 wd3            r15            lk la  e_rd1                              e_rd2                              b1          b2
        vt[0]  = mk(3, 0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,                             32'h0,                             0,          0);
        vt[1]  = mk(5, 1, 1, 5, 32'h12345678, 32'h0,        0, 0, BYP ? 32'h12345678 : 32'h0,        32'h0,                             0,          0);
        vt[2]  = mk(5, 15,0, 0, 32'h0,        32'h00000100, 0, 0, 32'h12345678,                      32'h00000100,                      0,          0);
        vt[3]  = mk(15,5, 1, 15,32'hFFFFFFFF, 32'h40,       1, 15,32'h40,                            32'h12345678,                      0,          0);
        vt[4]  = mk(15,15,0, 0, 32'h0,        32'h40,       0, 0, 32'h40,                            32'h40,                            0,          0);
        vt[5]  = mk(0, 0, 1, 7, 32'h11,       32'h0,        0, 0, 32'h0,                             32'h0,                             0,          0);
        vt[6]  = mk(7, 7, 1, 7, 32'hA5A5A5A5, 32'h0,        0, 0, BYP ? 32'hA5A5A5A5 : 32'h11,       BYP ? 32'hA5A5A5A5 : 32'h11,       0,          0);
        vt[7]  = mk(7, 7, 0, 0, 32'h0,        32'h0,        0, 0, 32'hA5A5A5A5,                      32'hA5A5A5A5,                      0,          0);
        vt[8]  = mk(2, 2, 0, 0, 32'h0,        32'h0,        1, 2, 32'h0,                             32'h0,                             0,          0);
        vt[9]  = mk(0, 2, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,                             32'h0,                             0,          1);
        vt[10] = mk(0, 2, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,                             32'h0,                             0,          1);
        vt[11] = mk(2, 2, 1, 2, 32'h0000CAFE, 32'h0,        0, 0, BYP ? 32'hCAFE : 32'h0,            BYP ? 32'hCAFE : 32'h0,            !BYP,       !BYP);
        vt[12] = mk(2, 2, 0, 0, 32'h0,        32'h0,        0, 0, 32'hCAFE,                          32'hCAFE,                          0,          0);
        vt[13] = mk(9, 9, 1, 9, 32'h77,       32'h0,        1, 9, BYP ? 32'h77 : 32'h0,              BYP ? 32'h77 : 32'h0,              BYP,        BYP);
        vt[14] = mk(9, 9, 0, 0, 32'h0,        32'h0,        0, 0, 32'h77,                            32'h77,                            1,          1);
        vt[15] = mk(4, 5, 1, 5, 32'h55,       32'h0,        1, 4, 32'h0,                             BYP ? 32'h55 : 32'h12345678,       0,          0);
        vt[16] = mk(4, 5, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0,                             32'h55,                            1,          0);
        vt[17] = mk(4, 9, 0, 0, 32'h0,        32'h0,        1, 4, 32'h0,                             32'h77,                            1,          1);
        vt[18] = mk(4, 4, 1, 4, 32'h44,       32'h0,        0, 0, BYP ? 32'h44 : 32'h0,              BYP ? 32'h44 : 32'h0,              !BYP,       !BYP);
        vt[19] = mk(4, 15,0, 0, 32'h0,        32'h0000ABCD, 0, 0, 32'h44,                            32'h0000ABCD,                      0,          0);

        // Reset entry, held across a clock edge with a write pending on the inputs.
        idle_inputs();
        RST_N = 1'b1;
        #1 RST_N = 1'b0;
        bus.WE3 = 1'b1; bus.A3 = 4'd3; bus.WD3 = 32'h99999999;
        bus.LOCK_EN = 1'b1; bus.LOCK_A = 4'd3; bus.A1 = 4'd3; bus.A2 = 4'd3;
        #12;
        chk_outs("reset", 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge CLK);
        idle_inputs();
        RST_N = 1'b1;

        for (int i = 0; i < NV; i++) begin
            apply(vt[i]);
            chk_outs($sformatf("v%0d", i), vt[i].e_rd1, vt[i].e_rd2, vt[i].e_b1, vt[i].e_b2);
        end

        // Load 0xDEADBEEF into RD1, then reset mid-cycle without a clock edge.
        apply(mk(0, 0, 1, 3, 32'hDEADBEEF, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0));
        apply(mk(3, 9, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0));
        chk_outs("pre_rst", 32'hDEADBEEF, 32'h77, 1'b0, 1'b1);
        #2 RST_N = 1'b0;
        #1;
        chk_outs("async_rst", 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge CLK);
        RST_N = 1'b1;
        apply(mk(3, 9, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0));
        chk_outs("post_rst", 32'h0, 32'h0, 1'b0, 1'b0);

        // Write and lock in flight when reset hits: both must be discarded.
        @(negedge CLK);
        bus.WE3 = 1'b1; bus.A3 = 4'd6; bus.WD3 = 32'h66; bus.LOCK_EN = 1'b1; bus.LOCK_A = 4'd6;
        #2 RST_N = 1'b0;
        #4;
        idle_inputs();
        @(negedge CLK);
        RST_N = 1'b1;
        apply(mk(6, 6, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0));
        chk_outs("inflight_rst", 32'h0, 32'h0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
